// File: rtl/bp_update_sched.sv
// ---------------------------------------------------------------------------
// bp_update_sched
//
// Scheduler and initialiser for the branch-predictor tables (BTB and BHT).
// Out of reset, and on every table flush, it sweeps all table indices and
// issues one clear per cycle (INIT). It then accepts resolved-branch updates
// into an in-order queue and dispatches each one to the BTB or BHT write port
// (RUN). RAS-class and no-predictor updates are accepted, counted and dropped.
//
// Handshakes: every valid/ready pair transfers on a rising clock edge where
// both valid and ready are high. Once a valid is raised, it and its data stay
// stable until ready, except that a table flush withdraws it.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_tables_i       discard the queue and re-clear both tables
//   upd_*                resolved-branch update input (valid/ready)
//   btb_*                BTB write request output (valid/ready)
//   bht_*                BHT write request output (valid/ready)
//   clr_valid_o/idx_o    per-cycle table clear during INIT
//   init_busy_o          high while in INIT (exposes the FSM state)
//   drop_cnt_o           saturating count of discarded RAS/none updates
// ---------------------------------------------------------------------------
module bp_update_sched #(
   parameter int VLEN       = 64,
   parameter int DEPTH      = 4,
   parameter int NR_ENTRIES = 64
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          flush_tables_i,
   input  logic                          upd_valid_i,
   output logic                          upd_ready_o,
   input  logic [1:0]                    upd_sel_i,
   input  logic                          upd_taken_i,
   input  logic [VLEN-1:0]               upd_vpc_i,
   input  logic [VLEN-1:0]               upd_addr_i,
   output logic                          btb_valid_o,
   input  logic                          btb_ready_i,
   output logic [VLEN-1:0]               btb_vpc_o,
   output logic [VLEN-1:0]               btb_target_o,
   output logic                          bht_valid_o,
   input  logic                          bht_ready_i,
   output logic [VLEN-1:0]               bht_vpc_o,
   output logic                          bht_taken_o,
   output logic                          clr_valid_o,
   output logic [$clog2(NR_ENTRIES)-1:0] clr_idx_o,
   output logic                          init_busy_o,
   output logic [7:0]                    drop_cnt_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int IDX_W = $clog2(NR_ENTRIES);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NR_ENTRIES - 1);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Only BTB/BHT updates are stored, so one bit selects the target table.
   typedef struct packed {
      logic            is_bht;
      logic            taken;
      logic [VLEN-1:0] vpc;
      logic [VLEN-1:0] addr;
   } entry_t;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       drop_cnt_q, drop_cnt_d;
   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];

   logic   run;
   logic   full;
   logic   empty;
   logic   upd_hs;
   logic   push;
   logic   drop;
   logic   pop;
   entry_t head;

   // Output decode: everything below is derived from registered state only.
   always_comb begin
      run   = (state_q == ST_RUN);
      full  = (cnt_q == CNT_FULL);
      empty = (cnt_q == '0);
      head  = mem_q[rd_ptr_q];

      clr_valid_o = !run;
      init_busy_o = !run;
      clr_idx_o   = idx_q;
      drop_cnt_o  = drop_cnt_q;

      upd_ready_o = run && !full;
      btb_valid_o = run && !empty && !head.is_bht;
      bht_valid_o = run && !empty &&  head.is_bht;

      // Data is zeroed while its valid is low so idle outputs are clean.
      btb_vpc_o    = btb_valid_o ? head.vpc  : '0;
      btb_target_o = btb_valid_o ? head.addr : '0;
      bht_vpc_o    = bht_valid_o ? head.vpc  : '0;
      bht_taken_o  = bht_valid_o ? head.taken : 1'b0;
   end

   // Next-state logic.
   always_comb begin
      upd_hs = upd_valid_i && upd_ready_o;
      // An update accepted in the flush cycle is thrown away with the queue.
      push   = upd_hs && !upd_sel_i[1] && !flush_tables_i;
      drop   = upd_hs &&  upd_sel_i[1] && !flush_tables_i;
      pop    = (btb_valid_o && btb_ready_i) || (bht_valid_o && bht_ready_i);

      state_d    = state_q;
      idx_d      = idx_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      drop_cnt_d = drop_cnt_q;
      mem_d      = mem_q;

      case (state_q)
         ST_INIT: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
               state_d = ST_RUN;
               idx_d   = '0;
            end
         end
         default: begin
            if (push) begin
               mem_d[wr_ptr_q] = '{is_bht: upd_sel_i[0], taken: upd_taken_i,
                                   vpc: upd_vpc_i, addr: upd_addr_i};
               wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
               rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
               2'b10:   cnt_d = cnt_q + 1'b1;
               2'b01:   cnt_d = cnt_q - 1'b1;
               default: cnt_d = cnt_q;
            endcase
            if (drop && (drop_cnt_q != 8'hFF)) begin
               drop_cnt_d = drop_cnt_q + 8'd1;
            end
         end
      endcase

      // Flush overrides everything except the drop counter.
      if (flush_tables_i) begin
         state_d  = ST_INIT;
         idx_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_INIT;
         idx_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         drop_cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         drop_cnt_q <= drop_cnt_d;
         mem_q      <= mem_d;
      end
   end

endmodule
